// File: rtl/pic_pkg.sv
// Shared definitions for the PIC read/write control stage: state encoding,
// command-word bit positions and data bus buffer read selects.
package pic_pkg;

   typedef enum logic [2:0] {
      WAIT_ICW1,
      WAIT_ICW2,
      WAIT_ICW3,
      WAIT_ICW4,
      READY
   } state_e;

   localparam int ICW1_IC4  = 0;
   localparam int ICW1_SNGL = 1;
   localparam int ICW1_LTIM = 3;
   localparam int ICW1_ID   = 4;

   localparam int ICW4_UPM  = 0;
   localparam int ICW4_AEOI = 1;
   localparam int ICW4_SFNM = 4;

   localparam int OCW_SEL3  = 3;

   localparam int OCW3_RIS  = 0;
   localparam int OCW3_RR   = 1;
   localparam int OCW3_P    = 2;
   localparam int OCW3_SMM  = 5;
   localparam int OCW3_ESMM = 6;

   localparam logic [1:0] SEL_IRR = 2'b10;
   localparam logic [1:0] SEL_ISR = 2'b11;
   localparam logic [1:0] SEL_VEC = 2'b00;

endpackage

// File: rtl/pin_synchronizer.sv
// Multi-flop synchroniser for raw CPU pins; resets to the inactive (high) pin level
// so no false edge is seen when reset is released.
module pin_synchronizer #(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] pins_i,
   output logic [WIDTH-1:0] sync_o
);

   logic [STAGES-1:0][WIDTH-1:0] stage_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stage_q <= '1;
      end else begin
         stage_q <= {stage_q[STAGES-2:0], pins_i};
      end
   end

   assign sync_o = stage_q[STAGES-1];

endmodule

// File: rtl/pic_rw_control.sv
// PIC read/write control: synchronises CPU pins, sequences ICW1-4 / OCW1-3
// writes into configuration registers and steers the data bus buffer read select.
module pic_rw_control
   import pic_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       CS_n,
   input  logic       RD_n,
   input  logic       WR_n,
   input  logic       A0,
   input  logic [7:0] command_word,
   input  logic       inta_drive,
   output logic       direction,
   output logic [1:0] read_register,
   output logic       init_strobe,
   output logic       init_done,
   output logic       ltim,
   output logic       single_mode,
   output logic       ic4,
   output logic [4:0] vector_base,
   output logic [7:0] cascade_cfg,
   output logic       upm,
   output logic       aeoi,
   output logic       sfnm,
   output logic [7:0] imr,
   output logic       ocw2_strobe,
   output logic [2:0] ocw2_cmd,
   output logic [2:0] ocw2_level,
   output logic       special_mask,
   output logic       poll_ack
);

   logic [3:0] pins_sync;
   logic       cs, rd, wr, a0;

   pin_synchronizer #(
      .WIDTH  (4),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .pins_i  ({CS_n, RD_n, WR_n, A0}),
      .sync_o  (pins_sync)
   );

   assign cs = ~pins_sync[3];
   assign rd = ~pins_sync[2];
   assign wr = ~pins_sync[1];
   assign a0 =  pins_sync[0];

   state_e     state_q, state_d;
   logic [7:0] data_q, data_d;
   logic       a0_cap_q, a0_cap_d;
   logic       cap_valid_q, cap_valid_d;
   logic       wr_prev_q, rd_prev_q;
   logic       ltim_q, ltim_d, single_q, single_d, ic4_q, ic4_d;
   logic [4:0] vector_base_q, vector_base_d;
   logic [7:0] cascade_q, cascade_d;
   logic       upm_q, upm_d, aeoi_q, aeoi_d, sfnm_q, sfnm_d;
   logic [7:0] imr_q, imr_d;
   logic       init_strobe_q, init_strobe_d;
   logic       ocw2_strobe_q, ocw2_strobe_d;
   logic [2:0] ocw2_cmd_q, ocw2_cmd_d, ocw2_level_q, ocw2_level_d;
   logic       special_mask_q, special_mask_d;
   logic       ris_q, ris_d;
   logic       poll_pending_q, poll_pending_d;
   logic       poll_read_q, poll_read_d;
   logic       poll_ack_q, poll_ack_d;
   logic       direction_q, direction_d;
   logic [1:0] read_register_q, read_register_d;
   logic       commit, rd_fall, plain_read;

   // Commit happens when synchronised WR falls after at least one chip-selected capture.
   assign commit     = wr_prev_q & ~wr & cap_valid_q;
   assign rd_fall    = rd_prev_q & ~rd;
   assign plain_read = cs & rd & ~wr & ~a0;

   always_comb begin
      state_d         = state_q;
      data_d          = data_q;
      a0_cap_d        = a0_cap_q;
      cap_valid_d     = cap_valid_q;
      ltim_d          = ltim_q;
      single_d        = single_q;
      ic4_d           = ic4_q;
      vector_base_d   = vector_base_q;
      cascade_d       = cascade_q;
      upm_d           = upm_q;
      aeoi_d          = aeoi_q;
      sfnm_d          = sfnm_q;
      imr_d           = imr_q;
      init_strobe_d   = 1'b0;
      ocw2_strobe_d   = 1'b0;
      ocw2_cmd_d      = ocw2_cmd_q;
      ocw2_level_d    = ocw2_level_q;
      special_mask_d  = special_mask_q;
      ris_d           = ris_q;
      poll_pending_d  = poll_pending_q;
      poll_read_d     = poll_read_q;
      poll_ack_d      = 1'b0;
      direction_d     = 1'b0;
      read_register_d = {1'b1, ris_q};

      if (cs & wr) begin
         data_d      = command_word;
         a0_cap_d    = a0;
         cap_valid_d = 1'b1;
      end

      if (inta_drive) begin
         direction_d     = 1'b1;
         read_register_d = SEL_VEC;
      end else if (plain_read) begin
         direction_d     = 1'b1;
         read_register_d = poll_pending_q ? SEL_VEC : {1'b1, ris_q};
         if (poll_pending_q) poll_read_d = 1'b1;
      end

      if (rd_fall & poll_read_q) begin
         poll_read_d    = 1'b0;
         poll_pending_d = 1'b0;
         poll_ack_d     = 1'b1;
      end

      // Write decode runs last so that ICW1 overrides any concurrent poll bookkeeping.
      if (commit) begin
         cap_valid_d = 1'b0;
         if (!a0_cap_q && data_q[ICW1_ID]) begin
            init_strobe_d  = 1'b1;
            ltim_d         = data_q[ICW1_LTIM];
            single_d       = data_q[ICW1_SNGL];
            ic4_d          = data_q[ICW1_IC4];
            imr_d          = 8'h00;
            special_mask_d = 1'b0;
            poll_pending_d = 1'b0;
            poll_read_d    = 1'b0;
            ris_d          = 1'b0;
            if (!data_q[ICW1_IC4]) begin
               upm_d  = 1'b0;
               aeoi_d = 1'b0;
               sfnm_d = 1'b0;
            end
            state_d = WAIT_ICW2;
         end else begin
            case (state_q)
               WAIT_ICW2: if (a0_cap_q) begin
                  vector_base_d = data_q[7:3];
                  if (!single_q)  state_d = WAIT_ICW3;
                  else if (ic4_q) state_d = WAIT_ICW4;
                  else            state_d = READY;
               end
               WAIT_ICW3: if (a0_cap_q) begin
                  cascade_d = data_q;
                  state_d   = ic4_q ? WAIT_ICW4 : READY;
               end
               WAIT_ICW4: if (a0_cap_q) begin
                  upm_d   = data_q[ICW4_UPM];
                  aeoi_d  = data_q[ICW4_AEOI];
                  sfnm_d  = data_q[ICW4_SFNM];
                  state_d = READY;
               end
               READY: begin
                  if (a0_cap_q) begin
                     imr_d = data_q;
                  end else if (!data_q[OCW_SEL3]) begin
                     ocw2_strobe_d = 1'b1;
                     ocw2_cmd_d    = data_q[7:5];
                     ocw2_level_d  = data_q[2:0];
                  end else begin
                     if (data_q[OCW3_RR])   ris_d          = data_q[OCW3_RIS];
                     if (data_q[OCW3_ESMM]) special_mask_d = data_q[OCW3_SMM];
                     if (data_q[OCW3_P])    poll_pending_d = 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= WAIT_ICW1;
         data_q          <= 8'h00;
         a0_cap_q        <= 1'b0;
         cap_valid_q     <= 1'b0;
         wr_prev_q       <= 1'b0;
         rd_prev_q       <= 1'b0;
         ltim_q          <= 1'b0;
         single_q        <= 1'b0;
         ic4_q           <= 1'b0;
         vector_base_q   <= 5'h00;
         cascade_q       <= 8'h00;
         upm_q           <= 1'b0;
         aeoi_q          <= 1'b0;
         sfnm_q          <= 1'b0;
         imr_q           <= 8'h00;
         init_strobe_q   <= 1'b0;
         ocw2_strobe_q   <= 1'b0;
         ocw2_cmd_q      <= 3'b000;
         ocw2_level_q    <= 3'b000;
         special_mask_q  <= 1'b0;
         ris_q           <= 1'b0;
         poll_pending_q  <= 1'b0;
         poll_read_q     <= 1'b0;
         poll_ack_q      <= 1'b0;
         direction_q     <= 1'b0;
         read_register_q <= SEL_IRR;
      end else begin
         state_q         <= state_d;
         data_q          <= data_d;
         a0_cap_q        <= a0_cap_d;
         cap_valid_q     <= cap_valid_d;
         wr_prev_q       <= wr;
         rd_prev_q       <= rd;
         ltim_q          <= ltim_d;
         single_q        <= single_d;
         ic4_q           <= ic4_d;
         vector_base_q   <= vector_base_d;
         cascade_q       <= cascade_d;
         upm_q           <= upm_d;
         aeoi_q          <= aeoi_d;
         sfnm_q          <= sfnm_d;
         imr_q           <= imr_d;
         init_strobe_q   <= init_strobe_d;
         ocw2_strobe_q   <= ocw2_strobe_d;
         ocw2_cmd_q      <= ocw2_cmd_d;
         ocw2_level_q    <= ocw2_level_d;
         special_mask_q  <= special_mask_d;
         ris_q           <= ris_d;
         poll_pending_q  <= poll_pending_d;
         poll_read_q     <= poll_read_d;
         poll_ack_q      <= poll_ack_d;
         direction_q     <= direction_d;
         read_register_q <= read_register_d;
      end
   end

   assign direction     = direction_q;
   assign read_register = read_register_q;
   assign init_strobe   = init_strobe_q;
   assign init_done     = (state_q == READY);
   assign ltim          = ltim_q;
   assign single_mode   = single_q;
   assign ic4           = ic4_q;
   assign vector_base   = vector_base_q;
   assign cascade_cfg   = cascade_q;
   assign upm           = upm_q;
   assign aeoi          = aeoi_q;
   assign sfnm          = sfnm_q;
   assign imr           = imr_q;
   assign ocw2_strobe   = ocw2_strobe_q;
   assign ocw2_cmd      = ocw2_cmd_q;
   assign ocw2_level    = ocw2_level_q;
   assign special_mask  = special_mask_q;
   assign poll_ack      = poll_ack_q;

endmodule

// File: tb/tb_pic_rw_control.sv
// Directed bench for pic_rw_control: initialisation sequences, OCW handling,
// read steering, poll handshake and reset behaviour.
module tb_pic_rw_control;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       CS_n = 1'b1, RD_n = 1'b1, WR_n = 1'b1, A0 = 1'b1;
   logic [7:0] command_word = 8'h00;
   logic       inta_drive = 1'b0;
   logic       direction;
   logic [1:0] read_register;
   logic       init_strobe, init_done, ltim, single_mode, ic4;
   logic [4:0] vector_base;
   logic [7:0] cascade_cfg;
   logic       upm, aeoi, sfnm;
   logic [7:0] imr;
   logic       ocw2_strobe;
   logic [2:0] ocw2_cmd, ocw2_level;
   logic       special_mask, poll_ack;

   int checks = 0;
   int errors = 0;
   int n_init = 0, n_ocw2 = 0, n_poll = 0;

   always #5 clk = ~clk;

   pic_rw_control #(.SYNC_STAGES(2)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .CS_n          (CS_n),
      .RD_n          (RD_n),
      .WR_n          (WR_n),
      .A0            (A0),
      .command_word  (command_word),
      .inta_drive    (inta_drive),
      .direction     (direction),
      .read_register (read_register),
      .init_strobe   (init_strobe),
      .init_done     (init_done),
      .ltim          (ltim),
      .single_mode   (single_mode),
      .ic4           (ic4),
      .vector_base   (vector_base),
      .cascade_cfg   (cascade_cfg),
      .upm           (upm),
      .aeoi          (aeoi),
      .sfnm          (sfnm),
      .imr           (imr),
      .ocw2_strobe   (ocw2_strobe),
      .ocw2_cmd      (ocw2_cmd),
      .ocw2_level    (ocw2_level),
      .special_mask  (special_mask),
      .poll_ack      (poll_ack)
   );

   // Strobe counters sampled mid-cycle; a one-cycle pulse adds exactly one.
   always @(negedge clk) begin
      if (init_strobe) n_init++;
      if (ocw2_strobe) n_ocw2++;
      if (poll_ack)    n_poll++;
   end

   task automatic cpu_write(input logic a, input logic [7:0] d);
      @(negedge clk);
      A0 = a; command_word = d; CS_n = 1'b0; WR_n = 1'b0;
      repeat (4) @(negedge clk);
      WR_n = 1'b1; CS_n = 1'b1;
      repeat (6) @(negedge clk);
      $display("write a0=%0d data=%h", a, d);
   endtask

   task automatic cpu_read_start(input logic a);
      @(negedge clk);
      A0 = a; CS_n = 1'b0; RD_n = 1'b0;
      repeat (4) @(negedge clk);
      $display("read a0=%0d direction=%0d read_register=%b", a, direction, read_register);
   endtask

   task automatic cpu_read_end();
      RD_n = 1'b1; CS_n = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if (direction !== 1'b0) begin errors++; $display("FAIL reset_direction: got %b expected 0", direction); end
      checks++; if (read_register !== 2'b10) begin errors++; $display("FAIL reset_read_register: got %b expected 10", read_register); end
      checks++; if (imr !== 8'h00) begin errors++; $display("FAIL reset_imr: got %h expected 00", imr); end
      checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b expected 0", init_done); end
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (vector_base !== 5'h00) begin errors++; $display("FAIL reset_vector_base: got %h expected 00", vector_base); end
   endtask

   task automatic test_init_single();
      int s;
      s = n_init;
      cpu_write(1'b0, 8'h13);
      checks++; if (n_init - s !== 1) begin errors++; $display("FAIL icw1_strobe_count: got %0d expected 1", n_init - s); end
      checks++; if ({ltim, single_mode, ic4} !== 3'b011) begin errors++; $display("FAIL icw1_bits: got %b expected 011", {ltim, single_mode, ic4}); end
      cpu_write(1'b1, 8'h48);
      checks++; if (vector_base !== 5'h09) begin errors++; $display("FAIL icw2_vector_base: got %h expected 09", vector_base); end
      checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL single_init_done_early: got %b expected 0", init_done); end
      cpu_write(1'b1, 8'h03);
      checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL single_init_done: got %b expected 1", init_done); end
      checks++; if ({sfnm, aeoi, upm} !== 3'b011) begin errors++; $display("FAIL icw4_bits: got %b expected 011", {sfnm, aeoi, upm}); end
      checks++; if (cascade_cfg !== 8'h00) begin errors++; $display("FAIL icw3_skipped: got %h expected 00", cascade_cfg); end
   endtask

   task automatic test_init_cascade();
      cpu_write(1'b0, 8'h11);
      checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL icw1_clears_init_done: got %b expected 0", init_done); end
      checks++; if (single_mode !== 1'b0) begin errors++; $display("FAIL cascade_single_mode: got %b expected 0", single_mode); end
      cpu_write(1'b1, 8'h20);
      checks++; if (vector_base !== 5'h04) begin errors++; $display("FAIL cascade_vector_base: got %h expected 04", vector_base); end
      cpu_write(1'b1, 8'h04);
      checks++; if (cascade_cfg !== 8'h04) begin errors++; $display("FAIL cascade_cfg: got %h expected 04", cascade_cfg); end
      checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL cascade_init_done_early: got %b expected 0", init_done); end
      cpu_write(1'b1, 8'h01);
      checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL cascade_init_done: got %b expected 1", init_done); end
      checks++; if ({aeoi, upm} !== 2'b01) begin errors++; $display("FAIL cascade_icw4: got %b expected 01", {aeoi, upm}); end
   endtask

   task automatic test_ocw1_ocw2();
      int s;
      cpu_write(1'b1, 8'hA5);
      checks++; if (imr !== 8'hA5) begin errors++; $display("FAIL ocw1_imr: got %h expected a5", imr); end
      s = n_ocw2;
      cpu_write(1'b0, 8'h63);
      checks++; if (n_ocw2 - s !== 1) begin errors++; $display("FAIL ocw2_strobe_count: got %0d expected 1", n_ocw2 - s); end
      checks++; if (ocw2_cmd !== 3'b011) begin errors++; $display("FAIL ocw2_cmd: got %b expected 011", ocw2_cmd); end
      checks++; if (ocw2_level !== 3'd3) begin errors++; $display("FAIL ocw2_level: got %0d expected 3", ocw2_level); end
      checks++; if (imr !== 8'hA5) begin errors++; $display("FAIL ocw2_keeps_imr: got %h expected a5", imr); end
   endtask

   task automatic test_ocw3_reads();
      int s;
      cpu_write(1'b0, 8'h0B);
      cpu_read_start(1'b0);
      checks++; if (direction !== 1'b1) begin errors++; $display("FAIL isr_read_direction: got %b expected 1", direction); end
      checks++; if (read_register !== 2'b11) begin errors++; $display("FAIL isr_read_select: got %b expected 11", read_register); end
      cpu_read_end();
      checks++; if (direction !== 1'b0) begin errors++; $display("FAIL read_release_direction: got %b expected 0", direction); end
      cpu_read_start(1'b1);
      checks++; if (direction !== 1'b0) begin errors++; $display("FAIL a0_read_direction: got %b expected 0", direction); end
      cpu_read_end();
      s = n_poll;
      cpu_write(1'b0, 8'h0C);
      cpu_read_start(1'b0);
      checks++; if (read_register !== 2'b00) begin errors++; $display("FAIL poll_read_select: got %b expected 00", read_register); end
      checks++; if (n_poll - s !== 0) begin errors++; $display("FAIL poll_ack_early: got %0d expected 0", n_poll - s); end
      cpu_read_end();
      checks++; if (n_poll - s !== 1) begin errors++; $display("FAIL poll_ack_count: got %0d expected 1", n_poll - s); end
      cpu_read_start(1'b0);
      checks++; if (read_register !== 2'b11) begin errors++; $display("FAIL post_poll_select: got %b expected 11", read_register); end
      cpu_read_end();
   endtask

   task automatic test_rd_wr_conflict();
      int s;
      s = n_ocw2;
      @(negedge clk);
      A0 = 1'b0; command_word = 8'h27; CS_n = 1'b0; RD_n = 1'b0; WR_n = 1'b0;
      repeat (4) @(negedge clk);
      checks++; if (direction !== 1'b0) begin errors++; $display("FAIL rdwr_direction: got %b expected 0", direction); end
      RD_n = 1'b1; WR_n = 1'b1; CS_n = 1'b1;
      repeat (6) @(negedge clk);
      $display("write+read a0=0 data=27");
      checks++; if (n_ocw2 - s !== 1) begin errors++; $display("FAIL rdwr_commit: got %0d expected 1", n_ocw2 - s); end
      checks++; if ({ocw2_cmd, ocw2_level} !== 6'b001_111) begin errors++; $display("FAIL rdwr_ocw2: got %b expected 001111", {ocw2_cmd, ocw2_level}); end
   endtask

   task automatic test_inta();
      @(negedge clk);
      inta_drive = 1'b1;
      repeat (2) @(negedge clk);
      $display("inta direction=%0d read_register=%b", direction, read_register);
      checks++; if (direction !== 1'b1) begin errors++; $display("FAIL inta_direction: got %b expected 1", direction); end
      checks++; if (read_register !== 2'b00) begin errors++; $display("FAIL inta_select: got %b expected 00", read_register); end
      inta_drive = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (direction !== 1'b0) begin errors++; $display("FAIL inta_release: got %b expected 0", direction); end
   endtask

   task automatic test_reset_mid_sequence();
      int si, so;
      cpu_write(1'b0, 8'h11);
      cpu_write(1'b1, 8'h20);
      si = n_init;
      cpu_write(1'b0, 8'h11);
      checks++; if (n_init - si !== 1) begin errors++; $display("FAIL icw1_in_icw3_strobe: got %0d expected 1", n_init - si); end
      checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL icw1_in_icw3_done: got %b expected 0", init_done); end
      @(negedge clk);
      A0 = 1'b1; command_word = 8'hF8; CS_n = 1'b0; WR_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      si = n_init; so = n_ocw2;
      repeat (2) @(negedge clk);
      checks++; if (imr !== 8'h00) begin errors++; $display("FAIL midreset_imr: got %h expected 00", imr); end
      checks++; if (direction !== 1'b0) begin errors++; $display("FAIL midreset_direction: got %b expected 0", direction); end
      WR_n = 1'b1; CS_n = 1'b1;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (6) @(negedge clk);
      $display("reset during ICW2 write");
      checks++; if ((n_init - si) + (n_ocw2 - so) !== 0) begin errors++; $display("FAIL midreset_strobes: got %0d expected 0", (n_init - si) + (n_ocw2 - so)); end
      cpu_write(1'b1, 8'hF8);
      checks++; if (vector_base !== 5'h00) begin errors++; $display("FAIL midreset_state_icw1: got %h expected 00", vector_base); end
      checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL midreset_init_done: got %b expected 0", init_done); end
   endtask

   initial begin
      test_reset();
      test_init_single();
      test_init_cascade();
      test_ocw1_ocw2();
      test_ocw3_reads();
      test_rd_wr_conflict();
      test_inta();
      test_reset_mid_sequence();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
